// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding icache request, branch-predicted
// next PC, and a circular fetch queue feeding decode; redirect flushes the wrong path.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          entry,
  output logic                           icache_req_valid,
  output logic [ADDR_WIDTH-1:0]          icache_req_addr,
  input  logic                           icache_req_ready,
  input  logic                           icache_resp_valid,
  input  logic [INSTR_WIDTH-1:0]         icache_resp_data,
  output logic [ADDR_WIDTH-1:0]          bp_pc,
  input  logic                           bp_taken,
  input  logic [ADDR_WIDTH-1:0]          bp_target,
  input  logic                           redirect_valid,
  input  logic [ADDR_WIDTH-1:0]          redirect_pc,
  output logic                           dec_valid,
  output logic [INSTR_WIDTH-1:0]         dec_instr,
  output logic [ADDR_WIDTH-1:0]          dec_pc,
  input  logic                           dec_ready,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  req_pc;
  logic [ADDR_WIDTH-1:0]  q_pc    [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] q_instr [QUEUE_DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [CNT_W-1:0]       count;
  logic                   has_space;
  logic                   req_fire;
  logic                   push;
  logic                   pop;
  logic [ADDR_WIDTH-1:0]  next_seq_pc;

  // Credit counts only queued entries: the single in-flight response always fits.
  assign has_space        = count < CNT_W'(QUEUE_DEPTH);
  assign icache_req_valid = (state == REQ) && has_space;
  assign icache_req_addr  = fetch_pc;
  assign req_fire         = icache_req_valid && icache_req_ready;
  assign push             = (state == WAIT) && icache_resp_valid && !redirect_valid;
  assign pop              = dec_valid && dec_ready && !redirect_valid;
  assign next_seq_pc      = req_pc + ADDR_WIDTH'(INSTR_BYTES);

  assign bp_pc       = req_pc;
  assign dec_valid   = count != '0;
  assign dec_instr   = q_instr[head];
  assign dec_pc      = q_pc[head];
  assign queue_count = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= entry;
      req_pc   <= '0;
    end else begin
      if (req_fire) req_pc <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        // A request still in flight after this edge must have its response eaten.
        if ((((state == WAIT) || (state == DROP)) && !icache_resp_valid) || req_fire)
          state <= DROP;
        else
          state <= REQ;
      end else begin
        case (state)
          IDLE: state <= REQ;
          REQ:  if (req_fire) state <= WAIT;
          WAIT: if (icache_resp_valid) begin
                  fetch_pc <= bp_taken ? bp_target : next_seq_pc;
                  state    <= REQ;
                end
          DROP: if (icache_resp_valid) state <= REQ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_pc[tail]    <= req_pc;
        q_instr[tail] <= icache_resp_data;
        tail          <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count == CNT_W'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, multi-cycle corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] entry = 64'h1000;
  logic        icache_req_valid;
  logic [63:0] icache_req_addr;
  logic        icache_req_ready = 1'b0;
  logic        icache_resp_valid = 1'b0;
  logic [31:0] icache_resp_data = '0;
  logic [63:0] bp_pc;
  logic        bp_taken = 1'b0;
  logic [63:0] bp_target = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        dec_ready = 1'b0;
  logic [2:0]  queue_count;

  fetch_unit #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .QUEUE_DEPTH(4), .INSTR_BYTES(4)) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_req_ready(icache_req_ready), .icache_resp_valid(icache_resp_valid),
    .icache_resp_data(icache_resp_data), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .bp_target(bp_target), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_ready(dec_ready), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // cache environment
  logic        env_pend = 1'b0;
  logic        env_hold = 1'b0;
  logic [63:0] env_addr = '0;
  int          env_delay = 0;
  int          lat_max = 0;
  int          hs_cnt = 0;
  int          resp_cnt = 0;

  // reference model
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic        use_model = 1'b0;
  logic        m_idle, m_busy, m_drop;
  logic [63:0] m_fpc, m_rpc;

  typedef struct {
    logic        taken;
    logic [63:0] target;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_dv;
    logic [63:0] e_pc;
    int          e_cnt;
  } vec_t;
  vec_t vt[9];

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    if (a == 64'h1008) return 32'h0000_006F;
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic tk, input logic [63:0] tg, input logic rq,
                              input logic [63:0] ad, input logic dv, input logic [63:0] pc,
                              input int cnt);
    vec_t v;
    v.taken = tk; v.target = tg; v.e_req = rq; v.e_addr = ad;
    v.e_dv = dv; v.e_pc = pc; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_req_valid();
    return !m_idle && !m_busy && (mq.size() < 4);
  endfunction

  task automatic model_check();
    chk("m_req_valid", icache_req_valid, m_req_valid());
    chk("m_req_addr", icache_req_addr, m_fpc);
    chk("m_bp_pc", bp_pc, m_rpc);
    chk("m_dec_valid", dec_valid, mq.size() != 0);
    chk("m_count", queue_count, mq.size());
    if (mq.size() != 0) begin
      chk("m_dec_pc", dec_pc, mq[0].pc);
      chk("m_dec_instr", dec_instr, mq[0].instr);
    end
  endtask

  task automatic model_update();
    logic fire;
    fire = m_req_valid() && icache_req_ready;
    if (redirect_valid) begin
      mq.delete();
      m_busy = fire || (m_busy && !icache_resp_valid);
      m_drop = m_busy;
      if (fire) m_rpc = m_fpc;
      m_fpc  = redirect_pc;
      m_idle = 1'b0;
    end else begin
      if (mq.size() != 0 && dec_ready) void'(mq.pop_front());
      if (m_busy && icache_resp_valid) begin
        if (!m_drop) begin
          mq.push_back('{m_rpc, icache_resp_data});
          m_fpc = bp_taken ? bp_target : m_rpc + 64'd4;
        end
        m_busy = 1'b0;
        m_drop = 1'b0;
      end
      if (fire) begin
        m_busy = 1'b1;
        m_rpc  = m_fpc;
      end
      m_idle = 1'b0;
    end
  endtask

  // One clock: observe/model at negedge, then drive the cache response after the edge.
  task automatic step();
    @(negedge clk);
    if (icache_resp_valid) resp_cnt++;
    if (icache_req_valid && icache_req_ready) begin
      hs_cnt++;
      env_pend  = 1'b1;
      env_addr  = icache_req_addr;
      env_delay = $urandom_range(0, lat_max);
    end
    if (use_model) begin
      model_check();
      model_update();
    end
    @(posedge clk); #1;
    icache_resp_valid = 1'b0;
    redirect_valid    = 1'b0;
    if (env_pend && !env_hold) begin
      if (env_delay == 0) begin
        icache_resp_valid = 1'b1;
        icache_resp_data  = instr_of(env_addr);
        env_pend          = 1'b0;
      end else begin
        env_delay--;
      end
    end
  endtask

  task automatic do_reset(input logic [63:0] e);
    reset = 1'b1; entry = e;
    icache_resp_valid = 1'b0; redirect_valid = 1'b0; bp_taken = 1'b0;
    env_pend = 1'b0; env_hold = 1'b0; hs_cnt = 0; resp_cnt = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_req_valid", icache_req_valid, 1'b0);
    chk("rst_req_addr", icache_req_addr, e);
    chk("rst_bp_pc", bp_pc, 64'h0);
    chk("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_dec_instr", dec_instr, 64'h0);
    chk("rst_dec_pc", dec_pc, 64'h0);
    chk("rst_count", queue_count, 64'h0);
    reset = 1'b0;
    m_idle = 1'b1; m_busy = 1'b0; m_drop = 1'b0; m_fpc = e; m_rpc = '0;
    mq.delete();
  endtask

  initial begin
    // Directed table: single-cycle cache, decoder always ready, branch at 0x1008.
    vt[0] = mk(0, 0,        1, 64'h1000, 0, 0,        0);
    vt[1] = mk(0, 0,        0, 64'h1000, 0, 0,        0);
    vt[2] = mk(0, 0,        1, 64'h1004, 1, 64'h1000, 1);
    vt[3] = mk(0, 0,        0, 64'h1004, 0, 0,        0);
    vt[4] = mk(0, 0,        1, 64'h1008, 1, 64'h1004, 1);
    vt[5] = mk(1, 64'h2000, 0, 64'h1008, 0, 0,        0);
    vt[6] = mk(0, 0,        1, 64'h2000, 1, 64'h1008, 1);
    vt[7] = mk(0, 0,        0, 64'h2000, 0, 0,        0);
    vt[8] = mk(0, 0,        1, 64'h2004, 1, 64'h2000, 1);

    lat_max = 0;
    icache_req_ready = 1'b1;
    dec_ready = 1'b1;
    do_reset(64'h1000);
    chk("idle_cycle_req_valid", icache_req_valid, 1'b0);
    step();
    for (int i = 0; i < 9; i++) begin
      chk("tbl_req_valid", icache_req_valid, vt[i].e_req);
      chk("tbl_req_addr", icache_req_addr, vt[i].e_addr);
      chk("tbl_dec_valid", dec_valid, vt[i].e_dv);
      chk("tbl_count", queue_count, vt[i].e_cnt);
      if (vt[i].e_dv) begin
        chk("tbl_dec_pc", dec_pc, vt[i].e_pc);
        chk("tbl_dec_instr", dec_instr, instr_of(vt[i].e_pc));
      end
      bp_taken  = vt[i].taken;
      bp_target = vt[i].target;
      step();
    end
    bp_taken = 1'b0;

    // Queue fill with decoder stalled, then a single pop.
    dec_ready = 1'b0;
    do_reset(64'h1000);
    for (int i = 0; i < 20; i++) step();
    chk("full_hs", hs_cnt, 4);
    chk("full_resp", resp_cnt, 4);
    chk("full_count", queue_count, 4);
    chk("full_req_valid", icache_req_valid, 1'b0);
    chk("full_head_pc", dec_pc, 64'h1000);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    chk("pop1_count", queue_count, 3);
    chk("pop1_req_valid", icache_req_valid, 1'b1);
    for (int i = 0; i < 10; i++) step();
    chk("refill_hs", hs_cnt, 5);
    chk("refill_count", queue_count, 4);
    chk("refill_req_valid", icache_req_valid, 1'b0);
    chk("refill_head_pc", dec_pc, 64'h1004);

    // Redirect in WAIT with 3 entries queued; in-flight response must be dropped.
    do_reset(64'h1000);
    for (int i = 0; i < 30 && queue_count != 3; i++) step();
    chk("b_count3", queue_count, 3);
    chk("b_req_addr", icache_req_addr, 64'h100C);
    env_hold = 1'b1;
    step();
    chk("b_wait_req_valid", icache_req_valid, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    step();
    chk("b_flush_count", queue_count, 0);
    chk("b_flush_dec_valid", dec_valid, 1'b0);
    chk("b_drop_req_valid", icache_req_valid, 1'b0);
    chk("b_drop_addr", icache_req_addr, 64'h3000);
    step();
    chk("b_drop2_req_valid", icache_req_valid, 1'b0);
    env_hold = 1'b0;
    step();
    chk("b_dropresp_req_valid", icache_req_valid, 1'b0);
    step();
    chk("b_after_req_valid", icache_req_valid, 1'b1);
    chk("b_after_addr", icache_req_addr, 64'h3000);
    chk("b_after_count", queue_count, 0);
    dec_ready = 1'b1;
    for (int i = 0; i < 10 && !dec_valid; i++) step();
    chk("b_first_dec_valid", dec_valid, 1'b1);
    chk("b_first_dec_pc", dec_pc, 64'h3000);

    // Redirect coinciding with a response and a pop: no DROP.
    dec_ready = 1'b0;
    do_reset(64'h1000);
    for (int i = 0; i < 20 && queue_count != 1; i++) step();
    chk("c_count1", queue_count, 1);
    step();
    chk("c_resp_now", icache_resp_valid, 1'b1);
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h4000;
    step();
    chk("c_count", queue_count, 0);
    chk("c_dec_valid", dec_valid, 1'b0);
    chk("c_req_valid", icache_req_valid, 1'b1);
    chk("c_req_addr", icache_req_addr, 64'h4000);
    for (int i = 0; i < 10 && !dec_valid; i++) step();
    chk("c_first_dec_pc", dec_pc, 64'h4000);

    // Reset mid-WAIT, then stale responses in IDLE and REQ.
    do_reset(64'h1000);
    env_hold = 1'b1;
    step(); step();
    chk("d_wait_req_valid", icache_req_valid, 1'b0);
    #2 reset = 1'b1; entry = 64'h5000;
    #1;
    chk("d_async_req_valid", icache_req_valid, 1'b0);
    chk("d_async_addr", icache_req_addr, 64'h5000);
    env_pend = 1'b0; env_hold = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    icache_req_ready = 1'b0;
    icache_resp_valid = 1'b1; icache_resp_data = 32'hDEAD_BEEF;
    step();
    chk("d_idle_stale_dv", dec_valid, 1'b0);
    chk("d_idle_stale_cnt", queue_count, 0);
    chk("d_req_valid", icache_req_valid, 1'b1);
    chk("d_req_addr", icache_req_addr, 64'h5000);
    icache_resp_valid = 1'b1;
    step();
    chk("d_req_stale_dv", dec_valid, 1'b0);
    chk("d_req_stale_cnt", queue_count, 0);
    chk("d_req_addr2", icache_req_addr, 64'h5000);

    // Randomized run against the reference model.
    lat_max = 2;
    dec_ready = 1'b0;
    do_reset({32'h0, $urandom} & ~64'h3);
    use_model = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      icache_req_ready = $urandom_range(0, 3) != 0;
      dec_ready        = $urandom_range(0, 2) != 0;
      bp_taken         = $urandom_range(0, 3) == 0;
      bp_target        = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = {$urandom, $urandom} & ~64'h3;
      end
      step();
    end
    use_model = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
